// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the LSU.
// Round-robin on contention, one outstanding transaction, registered
// responses, and a watchdog that force-completes unanswered transactions.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BYTE_DATA_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_req,
    input  logic [DATA_WIDTH-1:0]      inst_addr,
    output logic                       inst_valid,
    output logic [DATA_WIDTH-1:0]      inst_data,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [BYTE_DATA_WIDTH-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    typedef enum logic {
        PORT_INST,
        PORT_DATA
    } port_t;

    // Watchdog compares against limit-1 so the timeout is taken in the
    // TIMEOUT_CYCLES-th BUSY cycle rather than one cycle later.
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    port_t                last_grant_q;
    logic [CNT_WIDTH-1:0] wd_q;
    logic                 timed_out_q;

    logic busy;
    logic grant_inst;
    logic grant_data;
    logic timeout_hit;
    logic complete;

    // Grant and completion conditions shared by the FSM and the datapath
    always_comb begin
        busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
        grant_inst  = (state_q == IDLE) && inst_req &&
                      (!data_req || (last_grant_q == PORT_DATA));
        grant_data  = (state_q == IDLE) && data_req && !grant_inst;
        timeout_hit = busy && !mem_valid && (wd_q == WD_LAST);
        complete    = busy && (mem_valid || timeout_hit);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_inst) begin
                    state_d = BUSY_I;
                end else if (grant_data) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (complete) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the state and grant registers
    always_comb begin
        mem_req    = busy;
        inst_valid = (state_q == DONE) && (last_grant_q == PORT_INST);
        data_valid = (state_q == DONE) && (last_grant_q == PORT_DATA);
        bus_error  = (state_q == DONE) && timed_out_q;
    end

    // Request latching at grant, response capture at completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PORT_DATA;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            inst_data    <= '0;
            rdata        <= '0;
            timed_out_q  <= 1'b0;
        end else begin
            if (grant_inst) begin
                last_grant_q <= PORT_INST;
                mem_we       <= 1'b0;
                mem_be       <= '1;
                mem_addr     <= inst_addr;
                mem_wdata    <= '0;
            end else if (grant_data) begin
                last_grant_q <= PORT_DATA;
                mem_we       <= data_we;
                mem_be       <= byte_enable;
                mem_addr     <= data_addr;
                mem_wdata    <= wdata;
            end
            if (complete) begin
                timed_out_q <= timeout_hit;
                if (last_grant_q == PORT_INST) begin
                    inst_data <= timeout_hit ? '0 : mem_rdata;
                end else begin
                    rdata <= timeout_hit ? '0 : mem_rdata;
                end
            end
        end
    end

    // Watchdog: counts unanswered BUSY cycles, cleared in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else if (state_q == DONE) begin
            wd_q <= '0;
        end else if (busy && !mem_valid) begin
            wd_q <= wd_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for solo fetch/store,
// hand sequences for contention, timeout, mid-transaction reset, stability.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] wdata = '0;
    logic        data_valid;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .DATA_WIDTH      (32),
        .BYTE_DATA_WIDTH (4),
        .TIMEOUT_CYCLES  (255),
        .CNT_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .data_req    (data_req),
        .data_we     (data_we),
        .byte_enable (byte_enable),
        .data_addr   (data_addr),
        .wdata       (wdata),
        .data_valid  (data_valid),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  be;
        logic [31:0] daddr;
        logic [31:0] wd;
        logic        mvalid;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_ivalid;
        logic        e_dvalid;
        logic [31:0] e_idata;
        logic [31:0] e_rdata;
        logic        e_berr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Field order: ireq iaddr dreq dwe be daddr wdata mvalid mrdata |
        //              mreq mwe mbe maddr mwdata ivalid dvalid idata rdata berr
        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h00A00093,
                    1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 1'b0, 32'h00A00093, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0, 32'h00A00093, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h2000, 32'hCAFEBABE, 1'b0, 32'h0,
                    1'b1, 1'b1, 4'h3, 32'h2000, 32'hCAFEBABE, 1'b0, 1'b0, 32'h00A00093, 32'h0, 1'b0};
        vecs[4] = vecs[3];
        vecs[5] = vecs[3];
        vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h2000, 32'hCAFEBABE, 1'b1, 32'h12345678,
                    1'b0, 1'b1, 4'h3, 32'h2000, 32'hCAFEBABE, 1'b0, 1'b1, 32'h00A00093, 32'h12345678, 1'b0};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b1, 4'h3, 32'h2000, 32'hCAFEBABE, 1'b0, 1'b0, 32'h00A00093, 32'h12345678, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_valids", {29'h0, inst_valid, data_valid, bus_error}, 32'h0);
        rst = 1'b1;

        // Solo fetch followed by solo store
        for (int i = 0; i < 8; i++) begin
            inst_req    = vecs[i].ireq;
            inst_addr   = vecs[i].iaddr;
            data_req    = vecs[i].dreq;
            data_we     = vecs[i].dwe;
            byte_enable = vecs[i].be;
            data_addr   = vecs[i].daddr;
            wdata       = vecs[i].wd;
            mem_valid   = vecs[i].mvalid;
            mem_rdata   = vecs[i].mrdata;
            tick();
            check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_mreq));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mwe));
            check($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].e_mbe));
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
            check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_ivalid));
            check($sformatf("v%0d_data_valid", i), 32'(data_valid), 32'(vecs[i].e_dvalid));
            check($sformatf("v%0d_inst_data", i), inst_data, vecs[i].e_idata);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
            check($sformatf("v%0d_bus_error", i), 32'(bus_error), 32'(vecs[i].e_berr));
        end
        mem_valid = 1'b0;

        // Contention from reset: both held, grants alternate inst, data, ...
        do_reset();
        inst_req    = 1'b1;
        inst_addr   = 32'h40;
        data_req    = 1'b1;
        data_we     = 1'b0;
        byte_enable = 4'hF;
        data_addr   = 32'h80;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d_mem_req", k), 32'(mem_req), 32'h1);
            check($sformatf("rr%0d_mem_addr", k), mem_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
            mem_valid = 1'b1;
            mem_rdata = 32'h1000 + 32'(k);
            tick();
            mem_valid = 1'b0;
            check($sformatf("rr%0d_inst_valid", k), 32'(inst_valid), (k % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("rr%0d_data_valid", k), 32'(data_valid), (k % 2 == 0) ? 32'h0 : 32'h1);
            if (k % 2 == 0) check($sformatf("rr%0d_inst_data", k), inst_data, 32'h1000 + 32'(k));
            else            check($sformatf("rr%0d_rdata", k), rdata, 32'h1000 + 32'(k));
            check($sformatf("rr%0d_mem_req_done", k), 32'(mem_req), 32'h0);
            tick();
            check($sformatf("rr%0d_idle_valids", k), {30'h0, inst_valid, data_valid}, 32'h0);
        end
        inst_req = 1'b0;
        data_req = 1'b0;

        // Timeout on a data read
        data_req    = 1'b1;
        data_we     = 1'b0;
        byte_enable = 4'hF;
        data_addr   = 32'h300;
        tick();
        n = 0;
        while (data_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        data_req = 1'b0;
        check("to_cycles", 32'(n), 32'd255);
        check("to_data_valid", 32'(data_valid), 32'h1);
        check("to_bus_error", 32'(bus_error), 32'h1);
        check("to_rdata", rdata, 32'h0);
        check("to_inst_valid", 32'(inst_valid), 32'h0);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD;
        tick();
        mem_valid = 1'b0;
        check("late_data_valid", 32'(data_valid), 32'h0);
        check("late_bus_error", 32'(bus_error), 32'h0);
        check("late_rdata", rdata, 32'h0);
        check("late_mem_req", 32'(mem_req), 32'h0);

        // Reset in the second BUSY cycle
        data_req    = 1'b1;
        data_we     = 1'b1;
        byte_enable = 4'hF;
        data_addr   = 32'h400;
        wdata       = 32'h55;
        tick();
        tick();
        check("mid_busy_mem_req", 32'(mem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'h0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_mem_wdata", mem_wdata, 32'h0);
        check("mid_rst_mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
        check("mid_rst_inst_data", inst_data, 32'h0);
        data_req = 1'b0;
        tick();
        tick();
        check("mid_rst_no_valid", {30'h0, inst_valid, data_valid}, 32'h0);
        rst = 1'b1;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h500;
        tick();
        check("reissue_mem_req", 32'(mem_req), 32'h1);
        check("reissue_mem_addr", mem_addr, 32'h500);
        mem_valid = 1'b1;
        mem_rdata = 32'hBEEF;
        tick();
        mem_valid = 1'b0;
        data_req  = 1'b0;
        check("reissue_data_valid", 32'(data_valid), 32'h1);
        check("reissue_rdata", rdata, 32'hBEEF);
        check("reissue_bus_error", 32'(bus_error), 32'h0);
        tick();

        // Input changes during BUSY_D do not reach the memory port
        data_req    = 1'b1;
        data_we     = 1'b1;
        byte_enable = 4'hC;
        data_addr   = 32'h600;
        wdata       = 32'h11112222;
        tick();
        data_addr   = 32'h700;
        wdata       = 32'h33334444;
        byte_enable = 4'h1;
        data_we     = 1'b0;
        tick();
        check("stab_mem_req", 32'(mem_req), 32'h1);
        check("stab_mem_addr", mem_addr, 32'h600);
        check("stab_mem_wdata", mem_wdata, 32'h11112222);
        check("stab_mem_be", 32'(mem_be), 32'hC);
        check("stab_mem_we", 32'(mem_we), 32'h1);
        mem_valid = 1'b1;
        mem_rdata = 32'h0;
        tick();
        mem_valid = 1'b0;
        data_req  = 1'b0;
        check("stab_data_valid", 32'(data_valid), 32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
